// File: rtl/relu_pool1.sv
// rtl/relu_pool1.sv - ReLU, 2x2 stride-2 max pool and saturating requantize after conv layer 1
// Drops wrap-around columns; even rows park horizontal maxima in a line buffer for the odd row.
module relu_pool1 #(
  parameter int IMG_W  = 28,
  parameter int CONV_W = 26,
  parameter int CONV_H = 26,
  parameter int SHIFT  = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_in,
  input  logic        in_valid,
  input  logic        sof,
  output logic [15:0] data_out,
  output logic        out_valid,
  output logic        frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(CONV_H);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_VALID = CW'(CONV_W);
  localparam logic [CW-1:0] COL_VLAST = CW'(CONV_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(CONV_H - 1);

  typedef enum logic {EVEN_ROW, ODD_ROW} phase_t;

  phase_t          state, state_nxt, cur_state;
  logic [CW-1:0]   col, col_nxt, cur_col;
  logic [RW-1:0]   row, row_nxt, cur_row;
  logic [30:0]     h_reg, r, h, lb_rd, p, q;
  logic [30:0]     line_buf [0:CONV_W/2-1];
  logic            in_conv, emit, last;
  logic [15:0]     sat;

  always_comb begin
    cur_col   = col;
    cur_row   = row;
    cur_state = state;
    // A qualified sof relocates this very sample to the frame origin
    if (in_valid && sof) begin
      cur_col   = '0;
      cur_row   = '0;
      cur_state = EVEN_ROW;
    end

    col_nxt   = col;
    row_nxt   = row;
    state_nxt = state;
    if (in_valid) begin
      col_nxt   = cur_col + 1'b1;
      row_nxt   = cur_row;
      state_nxt = cur_state;
      if (cur_col == COL_LAST) begin
        col_nxt   = '0;
        row_nxt   = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
        state_nxt = (cur_state == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
      end
    end

    r       = data_in[31] ? '0 : data_in[30:0];
    in_conv = in_valid && (cur_col < COL_VALID);
    h       = (h_reg > r) ? h_reg : r;
    lb_rd   = line_buf[cur_col[CW-1:1]];
    p       = (lb_rd > h) ? lb_rd : h;
    q       = p >> SHIFT;
    sat     = (q > 31'd32767) ? 16'h7fff : q[15:0];
    emit    = in_conv && cur_col[0] && (cur_state == ODD_ROW);
    last    = (cur_row == ROW_LAST) && (cur_col == COL_VLAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EVEN_ROW;
      col        <= '0;
      row        <= '0;
      h_reg      <= '0;
      data_out   <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      col        <= col_nxt;
      row        <= row_nxt;
      out_valid  <= emit;
      frame_done <= emit && last;
      if (emit)
        data_out <= sat;
      if (in_conv && !cur_col[0])
        h_reg <= r;
    end
  end

  // Always written in an even row before the odd row reads it, so no reset needed
  always_ff @(posedge clk) begin
    if (in_conv && cur_col[0] && (cur_state == EVEN_ROW))
      line_buf[cur_col[CW-1:1]] <= h;
  end

endmodule

// File: tb/tb_relu_pool1.sv
// tb/tb_relu_pool1.sv - directed self-checking bench for relu_pool1
// Per-sample out_valid/frame_done timing checks plus per-frame value checks.
module tb_relu_pool1;

  logic        clk;
  logic        rst_n;
  logic [31:0] data_in;
  logic        in_valid;
  logic        sof;
  logic [15:0] data_out;
  logic        out_valid;
  logic        frame_done;

  int n_chk  = 0;
  int n_pass = 0;
  int bad_v  = 0;
  int bad_fd = 0;
  int fd_cnt = 0;
  logic [15:0] outq[$];

  relu_pool1 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .in_valid   (in_valid),
    .sof        (sof),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else
      n_pass++;
  endtask

  function automatic logic [31:0] pix(input int kind, input int r, input int c);
    case (kind)
      0: return 32'd20480;
      1: return (r == 1 && c == 3) ? 32'd8192 : 32'hffff_fc18;
      2: return (c >= 26) ? 32'h7fff_ffff : 32'd4096;
      3: return 32'h7fff_ffff;
      default: begin
        if (r == 0 && c == 0) return 32'd4096;
        if (r == 0 && c == 1) return 32'd12288;
        if (r == 1 && c == 0) return 32'd8192;
        if (r == 1 && c == 1) return 32'd40960;
        return 32'd0;
      end
    endcase
  endfunction

  function automatic logic [15:0] exp_pool(input int kind, input int i);
    case (kind)
      0: return 16'd5;
      1: return (i == 1) ? 16'd2 : 16'd0;
      2: return 16'd1;
      3: return 16'd32767;
      default: return (i == 0) ? 16'd10 : 16'd0;
    endcase
  endfunction

  task automatic clear_capture();
    outq.delete();
    bad_v  = 0;
    bad_fd = 0;
    fd_cnt = 0;
  endtask

  task automatic send(input logic [31:0] d, input logic s, input int r, input int c, input bit gaps);
    logic ev;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        sof      = 1'($urandom_range(0, 1));
        data_in  = $urandom;
        @(posedge clk); #1;
        if (out_valid !== 1'b0) bad_v++;
        if (frame_done !== 1'b0) bad_fd++;
      end
    end
    data_in  = d;
    sof      = s;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sof      = 1'b0;
    ev = (r % 2 == 1) && (c % 2 == 1) && (c < 26);
    if (out_valid !== ev) bad_v++;
    if (frame_done !== (ev && r == 25 && c == 25)) bad_fd++;
    if (frame_done === 1'b1) fd_cnt++;
    if (out_valid === 1'b1) outq.push_back(data_out);
  endtask

  // Raster-order samples up to, but not including, (stop_r, stop_c)
  task automatic send_frame(input int kind, input bit gaps, input bit use_sof,
                            input int stop_r, input int stop_c);
    for (int r = 0; r < 26; r++)
      for (int c = 0; c < 28; c++) begin
        if (r > stop_r || (r == stop_r && c >= stop_c)) return;
        send(pix(kind, r, c), use_sof && r == 0 && c == 0, r, c, gaps);
      end
  endtask

  task automatic check_frame(input string tag, input int kind);
    int bad = 0;
    check({tag, "_count"}, outq.size(), 169);
    foreach (outq[i])
      if (outq[i] !== exp_pool(kind, i)) bad++;
    if (outq.size() > 0)
      check({tag, "_first"}, outq[0], exp_pool(kind, 0));
    check({tag, "_values_bad"}, bad, 0);
    check({tag, "_valid_timing_bad"}, bad_v, 0);
    check({tag, "_frame_done_timing_bad"}, bad_fd, 0);
    check({tag, "_frame_done_count"}, fd_cnt, 1);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sof      = 1'b0;
    data_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_data_out", data_out, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_frame_done", frame_done, 0);

    // Release reset alongside the first sample
    rst_n = 1'b1;
    clear_capture();
    send_frame(0, 1'b0, 1'b1, 26, 0);
    check_frame("const", 0);

    for (int k = 1; k <= 4; k++) begin
      clear_capture();
      send_frame(k, 1'b0, 1'b1, 26, 0);
      check_frame($sformatf("kind%0d", k), k);
    end

    clear_capture();
    send_frame(1, 1'b1, 1'b1, 26, 0);
    check_frame("gap_relu", 1);
    clear_capture();
    send_frame(4, 1'b1, 1'b1, 26, 0);
    check_frame("gap_maxsel", 4);

    // sof mid-frame at row 5 col 10
    clear_capture();
    send_frame(0, 1'b0, 1'b1, 5, 10);
    check("partial_valid_timing_bad", bad_v, 0);
    clear_capture();
    send_frame(1, 1'b0, 1'b1, 26, 0);
    check_frame("resync", 1);

    // Reset during row 13, right after an output
    clear_capture();
    send_frame(0, 1'b0, 1'b1, 13, 6);
    check("pre_reset_out_valid", out_valid, 1);
    check("pre_reset_data_out", data_out, 5);
    rst_n = 1'b0;
    #1;
    check("midreset_data_out", data_out, 0);
    check("midreset_out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_capture();
    send_frame(2, 1'b0, 1'b0, 26, 0);
    check_frame("post_reset", 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
